// File: rtl/pattern_scheduler.sv
// Frame-synchronous test-pattern scheduler: picks the pattern index for the pixel
// pipeline, changing it only at end of frame, from auto dwell or manual requests.
module pattern_scheduler #(
  parameter int NUM_PATTERNS = 4,
  parameter int DWELL_FRAMES = 120,
  parameter int H_TOTAL      = 2200,
  parameter int V_TOTAL      = 1125
) (
  input  logic        clk_pix,
  input  logic        rst_pix,
  input  logic [12:0] h,
  input  logic [12:0] v,
  input  logic        auto_en,
  input  logic        next_req,
  input  logic        sel_req,
  input  logic [3:0]  sel_idx,
  output logic [3:0]  pattern_sel,
  output logic        pattern_changed,
  output logic        pending,
  output logic [15:0] frame_cnt,
  output logic        state_dbg
);

  localparam int DW = $clog2(DWELL_FRAMES + 1);

  typedef enum logic {ST_MANUAL = 1'b0, ST_AUTO = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [3:0]     pattern_sel_q, pattern_sel_d;
  logic           changed_q, changed_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic           pend_next_q, pend_next_d;
  logic           pend_sel_q, pend_sel_d;
  logic [3:0]     pend_idx_q, pend_idx_d;

  logic           eof;
  logic           sel_ok;
  logic           auto_hit;
  logic [3:0]     adv_pat;

  assign eof = (h == 13'(H_TOTAL - 1)) && (v == 13'(V_TOTAL - 1));

  always_comb begin
    sel_ok   = sel_req && ({1'b0, sel_idx} < 5'(NUM_PATTERNS));
    auto_hit = (state_q == ST_AUTO) && (dwell_q == DW'(DWELL_FRAMES - 1));
    adv_pat  = (pattern_sel_q == 4'(NUM_PATTERNS - 1)) ? 4'd0 : pattern_sel_q + 4'd1;

    state_d       = auto_en ? ST_AUTO : ST_MANUAL;
    pattern_sel_d = pattern_sel_q;
    changed_d     = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    dwell_d       = dwell_q;
    // Requests in the eof cycle itself fold into the flags used at this boundary.
    pend_next_d   = pend_next_q | next_req;
    pend_sel_d    = pend_sel_q | sel_ok;
    pend_idx_d    = sel_ok ? sel_idx : pend_idx_q;

    if (eof) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (pend_sel_d) begin
        pattern_sel_d = pend_idx_d;
        changed_d     = 1'b1;
      end else if (pend_next_d || auto_hit) begin
        pattern_sel_d = adv_pat;
        changed_d     = 1'b1;
      end
      dwell_d     = changed_d ? '0 : dwell_q + DW'(1);
      pend_next_d = 1'b0;
      pend_sel_d  = 1'b0;
    end

    // MANUAL holds the dwell at zero, which also clears it on entry to AUTO.
    if (state_q != ST_AUTO) begin
      dwell_d = '0;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q       <= auto_en ? ST_AUTO : ST_MANUAL;
      pattern_sel_q <= 4'd0;
      changed_q     <= 1'b0;
      frame_cnt_q   <= 16'd0;
      dwell_q       <= '0;
      pend_next_q   <= 1'b0;
      pend_sel_q    <= 1'b0;
      pend_idx_q    <= 4'd0;
    end else begin
      state_q       <= state_d;
      pattern_sel_q <= pattern_sel_d;
      changed_q     <= changed_d;
      frame_cnt_q   <= frame_cnt_d;
      dwell_q       <= dwell_d;
      pend_next_q   <= pend_next_d;
      pend_sel_q    <= pend_sel_d;
      pend_idx_q    <= pend_idx_d;
    end
  end

  assign pattern_sel     = pattern_sel_q;
  assign pattern_changed = changed_q;
  assign pending         = pend_next_q | pend_sel_q;
  assign frame_cnt       = frame_cnt_q;
  assign state_dbg       = state_q;

endmodule
